// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Holds the FSM state encoding and the grant index width rule.
package stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Grant index width: clog2(n), never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = grant_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     rot_req;
  logic [IDX_W-1:0] rot_pos [N];

  // rot_req[k] is the request sitting k places after ptr.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    always_comb begin
      int p;
      p = int'(ptr) + gi;
      if (p >= N) begin
        p = p - N;
      end
      rot_pos[gi] = IDX_W'(p);
      rot_req[gi] = req[p];
    end
  end

  // Scan from the far end so the nearest request wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        found = 1'b1;
        idx   = rot_pos[k];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter merging N valid/ready byte streams into one
// registered output stream; a grant is held until the packet's last beat.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            in_valid,
  input  logic [N*DATA_W-1:0]     in_data,
  input  logic [N-1:0]            in_last,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [grant_w(N)-1:0]   grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        pkt_count
);

  localparam int GW = grant_w(N);

  arb_state_e        state_q;
  logic [GW-1:0]     ptr_q;
  logic [GW-1:0]     ptr_d;
  logic [GW-1:0]     grant_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [CNT_W-1:0]  pkt_count_q;
  logic [CNT_W-1:0]  pkt_count_d;

  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic              slot_free;
  logic              xfer;
  logic [N-1:0]      grant_oh;
  logic [DATA_W-1:0] in_data_arr [N];
  logic [DATA_W-1:0] g_data;
  logic              g_last;

  rr_pick #(
    .N     (N),
    .IDX_W (GW)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign slot_free = (state_q == LOCKED) && (!out_valid_q || out_ready);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign in_data_arr[gi] = in_data[gi*DATA_W +: DATA_W];
    assign grant_oh[gi]    = (grant_q == GW'(gi));
    assign in_ready[gi]    = slot_free && grant_oh[gi];
  end

  assign xfer   = |(in_valid & in_ready);
  assign g_last = |(in_last & grant_oh);

  always_comb begin
    g_data = '0;
    for (int k = 0; k < N; k++) begin
      g_data = g_data | (in_data_arr[k] & {DATA_W{grant_oh[k]}});
    end
  end

  assign ptr_d       = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;
  assign pkt_count_d = pkt_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= g_data;
        out_last_q  <= g_last;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // The lock has no timeout: a stalled owner keeps everyone else out.
          if (xfer && g_last) begin
            state_q     <= IDLE;
            ptr_q       <= ptr_d;
            pkt_count_q <= pkt_count_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCKED);
  assign pkt_count = pkt_count_q;

endmodule
